// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizes the PS/2 clock and data pad levels into clk and flags each falling edge of
// the synchronized PS/2 clock with a one-cycle strobe. Shared by the transmit and receive paths.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_p;
  logic [SYNC_STAGES-1:0] data_p;
  logic                   clk_prev;

  // Flops come out of reset at 1 so an idle bus never looks like a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_p    <= '1;
      data_p   <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_p    <= {clk_p[SYNC_STAGES-2:0], clk_in};
      data_p   <= {data_p[SYNC_STAGES-2:0], data_in};
      clk_prev <= clk_p[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_p[SYNC_STAGES-1];
  assign data_s = data_p[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (request-to-send, open-drain clock/data control).
// Define PS2_TX_TIMEOUT_EN to enable the watchdog from clock release to ack/bus idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  ps2_tx_state_e    state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [3:0]       bitcnt, bitcnt_d;
  logic             dbit, dbit_d;
  logic             done_d, err_d;
  logic             load;
  logic [7:0]       sh;
  logic             par;
  logic             clk_s, data_s, fall;

  ps2_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .clk_in (ps2_clk_in),
    .data_in(ps2_data_in),
    .clk_s  (clk_s),
    .data_s (data_s),
    .fall   (fall)
  );

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bitcnt_d = bitcnt;
    dbit_d   = dbit;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load     = 1'b1;
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          cnt_d   = '0;
          dbit_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        // The device samples on its rising edge, so the next bit goes out right after each fall.
        if (fall) begin
          bitcnt_d = bitcnt + 4'd1;
          if (bitcnt < 4'd8) begin
            dbit_d = ~sh[bitcnt[2:0]];
          end else if (bitcnt == 4'd8) begin
            dbit_d = ~par;
          end else begin
            dbit_d  = 1'b0;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          if (!data_s) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (state inside {RELEASE, ACK, WAIT_IDLE}) begin
      cnt_d = cnt_inc;
      if (cnt == TO_LAST) begin
        done_d  = 1'b0;
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bitcnt   <= '0;
      dbit     <= 1'b0;
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bitcnt   <= bitcnt_d;
      dbit     <= dbit_d;
      tx_done  <= done_d;
      tx_error <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sh  <= cmd_byte;
      par <= odd_parity(cmd_byte);
    end
  end

  assign cmd_ready   = (state == IDLE);
  assign tx_busy     = (state != IDLE);
  assign ps2_clk_oe  = (state == INHIBIT);
  // Start bit goes low in the final inhibit cycle, while the clock is still held.
  assign ps2_data_oe = ((state == INHIBIT) && (cnt == INH_LAST)) || ((state == RELEASE) && dbit);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on an open-drain bus, checked against frames built from the byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 20;
  localparam int TO  = 2000;
  localparam int SS  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int checks = 0;
  int errors = 0;
  int half = 20;
  int done_tot = 0;
  int err_tot = 0;

  int          inh_len, start_pos, start_cycles, d_done, d_err;
  logic        lat_clk_oe;
  logic [10:0] seen;
  bit          idle_ok;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_byte   (cmd_byte),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_tot++;
    if (tx_error === 1'b1) err_tot++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "time limit");
  end

  // Frame as the device sees it: start, LSB-first data, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic start_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat_clk_oe = ps2_clk_oe;
  endtask

  task automatic inhibit_phase();
    inh_len = 0;
    start_pos = -1;
    start_cycles = 0;
    while (ps2_clk_oe === 1'b1 && inh_len < 4 * INH) begin
      if (ps2_data_oe === 1'b1) begin
        if (start_pos < 0) start_pos = inh_len;
        start_cycles++;
      end
      inh_len++;
      @(negedge clk);
    end
  endtask

  task automatic device_clocks(input int nclk, input bit ack);
    seen[0] = ps2_data_in;
    for (int k = 1; k <= nclk; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) seen[k] = ps2_data_in;
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    idle_ok = (tx_busy === 1'b0);
  endtask

  task automatic frame(input logic [7:0] b, input bit ack);
    int d0, e0;
    d0 = done_tot;
    e0 = err_tot;
    start_cmd(b);
    inhibit_phase();
    device_clocks(11, ack);
    wait_idle();
    repeat (3) @(negedge clk);
    d_done = done_tot - d0;
    d_err  = err_tot - e0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 100000",
               {cmd_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({cmd_ready, tx_busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b required 1000",
               {cmd_ready, tx_busy, ps2_clk_oe, ps2_data_oe});
    end
  endtask

  task automatic test_set_leds();
    frame(CMD_SET_LEDS, 1'b1);
    checks++;
    if (lat_clk_oe !== 1'b1) begin
      errors++;
      $display("FAIL t1_latency: clk_oe one cycle after request got %b required 1", lat_clk_oe);
    end
    checks++;
    if (inh_len != INH) begin
      errors++;
      $display("FAIL t1_inhibit_len: got %0d required %0d", inh_len, INH);
    end
    checks++;
    if (start_pos != INH - 1 || start_cycles != 1) begin
      errors++;
      $display("FAIL t1_start_bit: at %0d for %0d cycles, required at %0d for 1", start_pos,
               start_cycles, INH - 1);
    end
    checks++;
    if (seen !== exp_frame(CMD_SET_LEDS)) begin
      errors++;
      $display("FAIL t1_bits: got %b required %b", seen, exp_frame(CMD_SET_LEDS));
    end
    checks++;
    if (d_done != 1 || d_err != 0) begin
      errors++;
      $display("FAIL t1_done: done %0d err %0d, required 1 and 0", d_done, d_err);
    end
    checks++;
    if (!idle_ok || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL t1_ready: cmd_ready got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_enable();
    frame(CMD_ENABLE, 1'b1);
    checks++;
    if (seen !== exp_frame(CMD_ENABLE)) begin
      errors++;
      $display("FAIL t2_bits: got %b required %b", seen, exp_frame(CMD_ENABLE));
    end
    checks++;
    if (d_done != 1 || d_err != 0) begin
      errors++;
      $display("FAIL t2_done: done %0d err %0d, required 1 and 0", d_done, d_err);
    end
  endtask

  task automatic test_no_ack();
    frame(8'h00, 1'b0);
    checks++;
    if (seen !== exp_frame(8'h00)) begin
      errors++;
      $display("FAIL t3_bits: got %b required %b", seen, exp_frame(8'h00));
    end
    checks++;
    if (d_err != 1 || d_done != 0) begin
      errors++;
      $display("FAIL t3_error: err %0d done %0d, required 1 and 0", d_err, d_done);
    end
    checks++;
    if (!idle_ok) begin
      errors++;
      $display("FAIL t3_idle: tx_busy got %b required 0", tx_busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit ack;
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      ack  = ($urandom_range(0, 3) != 0);
      half = $urandom_range(12, 30);
      frame(b, ack);
      checks++;
      if (seen !== exp_frame(b)) begin
        errors++;
        $display("FAIL rand_bits[%0d]: byte %h got %b required %b", i, b, seen, exp_frame(b));
      end
      checks++;
      if (d_done != int'(ack) || d_err != int'(!ack)) begin
        errors++;
        $display("FAIL rand_result[%0d]: done %0d err %0d, required %0d and %0d", i, d_done,
                 d_err, int'(ack), int'(!ack));
      end
      checks++;
      if (inh_len != INH) begin
        errors++;
        $display("FAIL rand_inhibit[%0d]: got %0d required %0d", i, inh_len, INH);
      end
    end
    half = 20;
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    start_cmd(CMD_RESET);
    inhibit_phase();
    n = 0;
    while (tx_error !== 1'b1 && n < TO + 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != TO) begin
      errors++;
      $display("FAIL t4_timeout_at: got %0d cycles after release required %0d", n, TO);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL t4_released: clk_oe,data_oe,ready got %b required 001",
               {ps2_clk_oe, ps2_data_oe, cmd_ready});
    end
    repeat (3) @(negedge clk);
  endtask
`else
  task automatic test_no_watchdog();
    int e0;
    e0 = err_tot;
    start_cmd(CMD_RESET);
    inhibit_phase();
    repeat (2 * TO) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b1 || err_tot != e0) begin
      errors++;
      $display("FAIL no_watchdog: busy %b errors %0d, required busy 1 and 0 errors", tx_busy,
               err_tot - e0);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_watchdog_reset: cmd_ready got %b required 1", cmd_ready);
    end
  endtask
`endif

  task automatic test_reset_midframe();
    start_cmd(CMD_RESET);
    inhibit_phase();
    device_clocks(5, 1'b0);
    repeat (half) @(negedge clk);
    dev_clk = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_busy, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL t5_async_reset: clk_oe,data_oe,busy,ready got %b required 0001",
               {ps2_clk_oe, ps2_data_oe, tx_busy, cmd_ready});
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    frame(CMD_RESET, 1'b1);
    checks++;
    if (seen !== exp_frame(CMD_RESET)) begin
      errors++;
      $display("FAIL t5_resend_bits: got %b required %b", seen, exp_frame(CMD_RESET));
    end
    checks++;
    if (d_done != 1 || d_err != 0) begin
      errors++;
      $display("FAIL t5_resend_done: done %0d err %0d, required 1 and 0", d_done, d_err);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_tot;
    @(negedge clk);
    cmd_byte  = CMD_ECHO;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_byte = CMD_ENABLE;
    inhibit_phase();
    device_clocks(11, 1'b1);
    wait_idle();
    checks++;
    if (!idle_ok || seen !== exp_frame(CMD_ECHO)) begin
      errors++;
      $display("FAIL t6_first: idle %0d bits %b required %b", idle_ok, seen, exp_frame(CMD_ECHO));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (ps2_clk_oe !== 1'b1) begin
      errors++;
      $display("FAIL t6_restart: clk_oe got %b required 1", ps2_clk_oe);
    end
    inhibit_phase();
    device_clocks(11, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (seen !== exp_frame(CMD_ENABLE)) begin
      errors++;
      $display("FAIL t6_second: got %b required %b", seen, exp_frame(CMD_ENABLE));
    end
    checks++;
    if (done_tot - d0 != 2 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL t6_done: done %0d ready %b, required 2 and 1", done_tot - d0, cmd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_enable();
    test_no_ack();
    test_random();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`else
    test_no_watchdog();
`endif
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
